// File: rtl/jedro_1_instr_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : jedro_1_instr_queue_if
//  Description : IFU/decode-facing signal bundle of the instruction queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jedro_1_instr_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic [DATA_WIDTH-1:0]        in_instr;
    logic [ADDR_WIDTH-1:0]        in_addr;
    logic                         in_valid;
    logic                         get_next_instr;
    logic                         flush;
    logic [DATA_WIDTH-1:0]        out_instr;
    logic [ADDR_WIDTH-1:0]        out_addr;
    logic                         out_valid;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         empty;

    // Environment side: IFU producer plus decode consumer
    modport master (
        output in_instr, in_addr, in_valid, flush, out_ready,
        input  get_next_instr, out_instr, out_addr, out_valid, count, full, empty
    );

    // Queue side
    modport slave (
        input  in_instr, in_addr, in_valid, flush, out_ready,
        output get_next_instr, out_instr, out_addr, out_valid, count, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/jedro_1_instr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : jedro_1_instr_queue
//  Description : Show-ahead instruction FIFO between IFU and decode with
//                single-cycle flush on taken jumps.
//  Revision    : 1.0 - initial release
// ============================================================================
module jedro_1_instr_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    jedro_1_instr_queue_if.slave    q
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_addr  [DEPTH];
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    // Accept depends only on state, flush and reset: no path from out_ready
    assign w_accept = !w_full && !q.flush && !rst;
    assign w_push   = q.in_valid && w_accept;
    assign w_pop    = !w_empty && q.out_ready && !q.flush;

    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is intentionally not cleared by reset or flush
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= q.in_instr;
            r_mem_addr[r_wr_ptr]  <= q.in_addr;
        end
    end

    assign q.get_next_instr = w_accept;
    assign q.out_valid      = !w_empty;
    assign q.out_instr      = w_empty ? '0 : r_mem_instr[r_rd_ptr];
    assign q.out_addr       = w_empty ? '0 : r_mem_addr[r_rd_ptr];
    assign q.count          = r_count;
    assign q.full           = w_full;
    assign q.empty          = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_instr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jedro_1_instr_queue
//  Description : Directed plus random bench for the instruction queue,
//                compared cycle by cycle against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jedro_1_instr_queue;
    localparam int c_DW    = 32;
    localparam int c_AW    = 32;
    localparam int c_DEPTH = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    jedro_1_instr_queue_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .DEPTH(c_DEPTH)) qif ();

    jedro_1_instr_queue #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .DEPTH(c_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of {addr, instr} entries, head at index 0
    logic [63:0] mq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] head;
        int          n;
        n    = mq.size();
        head = (n > 0) ? mq[0] : 64'h0;
        chk("count",          64'(qif.count),          64'(n));
        chk("full",           64'(qif.full),           64'(n == c_DEPTH));
        chk("empty",          64'(qif.empty),          64'(n == 0));
        chk("out_valid",      64'(qif.out_valid),      64'(n > 0));
        chk("out_instr",      64'(qif.out_instr),      64'(head[31:0]));
        chk("out_addr",       64'(qif.out_addr),       64'(head[63:32]));
        chk("get_next_instr", 64'(qif.get_next_instr),
            64'((n < c_DEPTH) && !qif.flush && !rst));
    endtask

    // Inputs are held from the preceding negedge; check, advance model, next negedge
    task automatic tick();
        bit do_push;
        bit do_pop;
        #1;
        check_all();
        do_push = qif.in_valid && (mq.size() < c_DEPTH) && !qif.flush && !rst;
        do_pop  = (mq.size() > 0) && qif.out_ready && !qif.flush && !rst;
        @(posedge clk);
        if (rst || qif.flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({qif.in_addr, qif.in_instr});
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] a, input bit rdy);
        qif.in_valid  = v;
        qif.in_instr  = w;
        qif.in_addr   = a;
        qif.out_ready = rdy;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        qif.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        tick();
        tick();
        chk("reset_empty", 64'(qif.empty), 64'd1);
        rst = 1'b0;

        // Fill to full with stalled decode
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i), 32'(4*i), 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("s1_full",    64'(qif.full),           64'd1);
        chk("s1_gni",     64'(qif.get_next_instr), 64'd0);
        chk("s1_head",    64'(qif.out_instr),      64'd0);
        tick();

        // Drain
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("s2_out_instr", 64'(qif.out_instr), 64'd0);

        // Streaming
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i), 32'(4*i), 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        tick();

        // Wrap-around
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1'b1, 32'(100 + 10*r + i), 32'(4*i), 1'b0);
                tick();
            end
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            for (int i = 0; i < 3; i++) tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(200 + i), 32'(16 + 4*i), 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("s4_full", 64'(qif.full),      64'd1);
        chk("s4_head", 64'(qif.out_instr), 64'd200);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) tick();

        // Flush with a concurrent input
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(50 + i), 32'(4*i), 1'b0);
            tick();
        end
        qif.flush = 1'b1;
        drive(1'b1, 32'd7, 32'd28, 1'b1);
        tick();
        qif.flush = 1'b0;
        #1;
        chk("s5_count_after_flush", 64'(qif.count), 64'd0);
        drive(1'b1, 32'd1, 32'd4, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("s5_instr", 64'(qif.out_instr), 64'd1);
        chk("s5_addr",  64'(qif.out_addr),  64'd4);
        tick();

        // Reset mid-stream
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'(60 + i), 32'(4*i), 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("s6_gni_after_rst", 64'(qif.get_next_instr), 64'd1);
        chk("s6_out_valid",     64'(qif.out_valid),      64'd0);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) != 0));
            qif.flush = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst       = 1'b0;
        qif.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
